// File: rtl/psum_accumulator.sv
// rtl/psum_accumulator.sv - partial-sum accumulator with round/shift/relu/saturate requantization
// Sums a counted run of adder-tree beats, then holds one requantized result until the consumer takes it.
module psum_accumulator #(
  parameter int ACC_DATA_WIDTH = 32,
  parameter int OUT_DATA_WIDTH = 8,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      clear_i,
  input  logic                      start_i,
  input  logic [CNT_WIDTH-1:0]      num_acc_i,
  input  logic [4:0]                shift_i,
  input  logic                      relu_i,
  input  logic                      in_valid_i,
  output logic                      in_ready_o,
  input  logic [ACC_DATA_WIDTH-1:0] in_data_i,
  output logic                      out_valid_o,
  input  logic                      out_ready_i,
  output logic [OUT_DATA_WIDTH-1:0] out_data_o,
  output logic                      busy_o,
  output logic                      done_o
);

  localparam int SUM_W = ACC_DATA_WIDTH + CNT_WIDTH;
  localparam logic signed [SUM_W-1:0] OUT_MAX =
    {{(SUM_W-OUT_DATA_WIDTH+1){1'b0}}, {(OUT_DATA_WIDTH-1){1'b1}}};
  localparam logic signed [SUM_W-1:0] OUT_MIN =
    {{(SUM_W-OUT_DATA_WIDTH+1){1'b1}}, {(OUT_DATA_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    OUTPUT = 2'd2
  } state_e;

  state_e                      state_q, state_d;
  logic signed [SUM_W-1:0]     acc_q, acc_d;
  logic [CNT_WIDTH-1:0]        cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0]        num_acc_q, num_acc_d;
  logic [4:0]                  shift_q, shift_d;
  logic                        relu_q, relu_d;
  logic [OUT_DATA_WIDTH-1:0]   out_data_q, out_data_d;
  logic                        done_q, done_d;

  logic                        accept;
  logic                        last_beat;
  logic signed [SUM_W-1:0]     sum;
  logic signed [SUM_W-1:0]     rnd_add;
  logic signed [SUM_W-1:0]     rounded;
  logic signed [SUM_W-1:0]     shifted;
  logic signed [SUM_W-1:0]     clamped;
  logic [OUT_DATA_WIDTH-1:0]   requant;

  assign accept    = in_valid_i && (state_q == ACCUM);
  assign last_beat = (cnt_q == (num_acc_q - CNT_WIDTH'(1)));

  // Requantization always works on the sum that includes the current beat.
  always_comb begin
    sum     = acc_q + {{CNT_WIDTH{in_data_i[ACC_DATA_WIDTH-1]}}, in_data_i};
    rnd_add = (shift_q != 5'd0) ? (SUM_W'(1) << (shift_q - 5'd1)) : '0;
    rounded = sum + rnd_add;
    shifted = rounded >>> shift_q;
    clamped = (relu_q && (shifted < 0)) ? '0 : shifted;
    if (clamped > OUT_MAX) begin
      requant = OUT_MAX[OUT_DATA_WIDTH-1:0];
    end else if (clamped < OUT_MIN) begin
      requant = OUT_MIN[OUT_DATA_WIDTH-1:0];
    end else begin
      requant = clamped[OUT_DATA_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      acc_q      <= '0;
      cnt_q      <= '0;
      num_acc_q  <= '0;
      shift_q    <= '0;
      relu_q     <= 1'b0;
      out_data_q <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      num_acc_q  <= num_acc_d;
      shift_q    <= shift_d;
      relu_q     <= relu_d;
      out_data_q <= out_data_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (clear_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (start_i) state_d = ACCUM;
        ACCUM:   if (accept && last_beat) state_d = OUTPUT;
        OUTPUT:  if (out_ready_i) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    num_acc_d  = num_acc_q;
    shift_d    = shift_q;
    relu_d     = relu_q;
    out_data_d = out_data_q;
    done_d     = 1'b0;
    if (clear_i) begin
      acc_d = '0;
      cnt_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            num_acc_d = (num_acc_i == '0) ? CNT_WIDTH'(1) : num_acc_i;
            shift_d   = shift_i;
            relu_d    = relu_i;
            acc_d     = '0;
            cnt_d     = '0;
          end
        end
        ACCUM: begin
          if (accept) begin
            acc_d = sum;
            cnt_d = cnt_q + CNT_WIDTH'(1);
            if (last_beat) out_data_d = requant;
          end
        end
        OUTPUT: begin
          if (out_ready_i) done_d = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    in_ready_o  = (state_q == ACCUM);
    out_valid_o = (state_q == OUTPUT);
    busy_o      = (state_q != IDLE);
    done_o      = done_q;
    out_data_o  = out_data_q;
  end

endmodule

// File: tb/tb_psum_accumulator.sv
// tb/tb_psum_accumulator.sv - scoreboard bench for psum_accumulator
// Driver pushes model results; a negedge monitor pops them on each output handshake.
module tb_psum_accumulator;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        clear_i = 1'b0;
  logic        start_i = 1'b0;
  logic [15:0] num_acc_i = '0;
  logic [4:0]  shift_i = '0;
  logic        relu_i = 1'b0;
  logic        in_valid_i = 1'b0;
  logic        in_ready_o;
  logic [31:0] in_data_i = '0;
  logic        out_valid_o;
  logic        out_ready_i = 1'b0;
  logic [7:0]  out_data_o;
  logic        busy_o;
  logic        done_o;

  psum_accumulator #(
    .ACC_DATA_WIDTH(32),
    .OUT_DATA_WIDTH(8),
    .CNT_WIDTH(16)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i), .start_i(start_i),
    .num_acc_i(num_acc_i), .shift_i(shift_i), .relu_i(relu_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_data_i(in_data_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_data_o(out_data_o),
    .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk_i = ~clk_i;

  int errors = 0;
  int checks = 0;
  int exp_q[$];
  int beats[$];
  bit hs_prev = 1'b0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: exact integer sum, round-half-up, floor division by 2^shift, relu, clamp.
  function automatic int model(input int sh, input bit rl);
    longint s = 0;
    longint v, d, q;
    foreach (beats[i]) s += longint'(beats[i]);
    v = (sh > 0) ? s + (longint'(1) << (sh - 1)) : s;
    d = longint'(1) << sh;
    if (v >= 0) q = v / d;
    else q = -((-v + d - 1) / d);
    if (rl && q < 0) q = 0;
    if (q > 127) q = 127;
    if (q < -128) q = -128;
    return int'(q);
  endfunction

  always @(negedge clk_i) begin
    if (!rst_ni) begin
      hs_prev = 1'b0;
    end else begin
      if (done_o || hs_prev) check("done_pulse", done_o, hs_prev);
      if (out_valid_o && out_ready_i) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got %0d expected no output", $signed(out_data_o));
        end else begin
          check("out_data", longint'($signed(out_data_o)), exp_q.pop_front());
        end
      end
      hs_prev = out_valid_o && out_ready_i && !clear_i;
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic feed_beats(input int count);
    for (int i = 0; i < count; i++) begin
      repeat ($urandom_range(0, 2)) begin
        in_valid_i = 1'b0;
        in_data_i  = $urandom;
        tick();
      end
      in_valid_i = 1'b1;
      in_data_i  = beats[i];
      @(negedge clk_i);
      check("in_ready_accum", in_ready_o, 1);
      tick();
      in_valid_i = 1'b0;
    end
  endtask

  task automatic run_job(input int n_cfg, input int sh, input bit rl,
                         input int stall, input bit start_in_out);
    logic [7:0] first;
    exp_q.push_back(model(sh, rl));
    start_i   = 1'b1;
    num_acc_i = 16'(n_cfg);
    shift_i   = 5'(sh);
    relu_i    = rl;
    tick();
    start_i = 1'b0;
    check("busy_after_start", busy_o, 1);
    feed_beats(beats.size());
    check("out_valid_latency", out_valid_o, 1);
    first = out_data_o;
    for (int k = 0; k < stall; k++) begin
      if (start_in_out) begin
        start_i   = 1'b1;
        num_acc_i = 16'd3;
      end
      @(negedge clk_i);
      check("stall_valid", out_valid_o, 1);
      check("stall_data", out_data_o, first);
      check("stall_in_ready", in_ready_o, 0);
      check("stall_done", done_o, 0);
      tick();
    end
    start_i     = 1'b0;
    out_ready_i = 1'b1;
    tick();
    out_ready_i = 1'b0;
    check("busy_after_hs", busy_o, 0);
    check("valid_after_hs", out_valid_o, 0);
    if (start_in_out) begin
      tick();
      tick();
      check("no_second_job", busy_o, 0);
    end
  endtask

  initial begin
    int n, nb;
    #2;
    @(negedge clk_i);
    check("rst_in_ready", in_ready_o, 0);
    check("rst_out_valid", out_valid_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_done", done_o, 0);
    check("rst_out_data", out_data_o, 0);
    rst_ni = 1'b1;

    beats = '{10, 20, -5, 7};
    run_job(4, 0, 0, 0, 0);
    beats = '{100, 100};
    run_job(2, 0, 0, 1, 0);
    beats = '{-200, -1};
    run_job(2, 0, 0, 0, 0);
    beats = '{6};
    run_job(1, 2, 0, 0, 0);
    beats = '{-6};
    run_job(1, 2, 0, 0, 0);
    beats = '{5};
    run_job(1, 2, 0, 0, 0);
    beats = '{-50};
    run_job(1, 0, 1, 0, 0);
    beats = '{3, -1, 40, 8, -2, 11};
    run_job(6, 1, 0, 5, 0);
    beats = '{9};
    run_job(0, 0, 0, 3, 1);

    beats = '{50, 60, 70, 80};
    start_i = 1'b1; num_acc_i = 16'd4; shift_i = '0; relu_i = 1'b0;
    tick();
    start_i = 1'b0;
    feed_beats(2);
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
    check("clear_busy", busy_o, 0);
    check("clear_out_valid", out_valid_o, 0);
    check("clear_in_ready", in_ready_o, 0);
    check("clear_done", done_o, 0);
    clear_i = 1'b1; start_i = 1'b1;
    tick();
    clear_i = 1'b0; start_i = 1'b0;
    check("clear_beats_start", busy_o, 0);
    beats = '{1, 2, 3, 4};
    run_job(4, 0, 0, 0, 0);

    beats = '{30, 30, 30, 30};
    start_i = 1'b1; num_acc_i = 16'd4;
    tick();
    start_i = 1'b0;
    feed_beats(2);
    #2 rst_ni = 1'b0;
    #1;
    check("midrst_in_ready", in_ready_o, 0);
    check("midrst_out_valid", out_valid_o, 0);
    check("midrst_busy", busy_o, 0);
    check("midrst_done", done_o, 0);
    check("midrst_out_data", out_data_o, 0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    beats = '{1, 2, 3, 4};
    run_job(4, 0, 0, 0, 0);

    for (int j = 0; j < 25; j++) begin
      n  = $urandom_range(0, 6);
      nb = (n == 0) ? 1 : n;
      beats.delete();
      for (int b = 0; b < nb; b++) begin
        if ($urandom_range(0, 1) == 1) beats.push_back(int'($urandom));
        else beats.push_back(int'($urandom_range(0, 600)) - 300);
      end
      run_job(n, $urandom_range(0, 31), 1'($urandom_range(0, 1)),
              $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    repeat (3) tick();
    check("scoreboard_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
